// File: rtl/m72_pkg.sv
// rtl/m72_pkg.sv - shared constants and types for the M72 interrupt controller
package m72_pkg;

    localparam logic [1:0] IRQ_REG_IRR_CMD = 2'd0;
    localparam logic [1:0] IRQ_REG_IMR     = 2'd1;
    localparam logic [1:0] IRQ_REG_VB      = 2'd2;
    localparam logic [1:0] IRQ_REG_ISR     = 2'd3;

    localparam int IRQ_CMD_NSEOI = 5;
    localparam int IRQ_CMD_SEOI  = 6;

    localparam int IRQ_IDX_W = 3;
    typedef logic [IRQ_IDX_W-1:0] irq_idx_t;

endpackage

// File: rtl/m72_prio_enc.sv
// rtl/m72_prio_enc.sv - lowest-set-bit priority encoder with valid flag
module m72_prio_enc
    import m72_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req_i,
    output irq_idx_t         idx_o,
    output logic             valid_o
);

    // Scan from the top so the lowest set index is the last assignment.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = irq_idx_t'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/m72_irq_ctrl.sv
// rtl/m72_irq_ctrl.sv - N-channel edge-latched, masked, nested-priority interrupt controller
module m72_irq_ctrl
    import m72_pkg::*;
#(
    parameter int         NUM_IRQ     = 8,
    parameter logic [7:0] VECTOR_BASE = 8'h20,
    parameter bit         AUTO_EOI    = 1'b0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               io_cs,
    input  logic               io_we,
    input  logic [1:0]         io_addr,
    input  logic [7:0]         io_din,
    output logic [7:0]         io_dout,
    output logic               io_ack,
    output logic               intr,
    input  logic               inta,
    output logic [7:0]         vec_out,
    output logic               vec_valid
);

    logic [NUM_IRQ-1:0] prev_q, irr_q, isr_q, imr_q;
    logic [NUM_IRQ-1:0] irr_d, isr_d, imr_d;
    logic [7:0]         vb_q, vb_d;
    logic [7:0]         io_dout_q, io_dout_d;
    logic [7:0]         vec_out_q, vec_out_d;
    logic               cs_q, io_ack_q, intr_q, vec_valid_q;

    logic [NUM_IRQ-1:0] cand, elig, eoi_clr, ack_set;
    irq_idx_t           isr_idx, sel_idx;
    logic               isr_any, sel_any;
    logic               access, wr;

    m72_prio_enc #(.WIDTH(NUM_IRQ)) u_isr_enc (
        .req_i   (isr_q),
        .idx_o   (isr_idx),
        .valid_o (isr_any)
    );

    m72_prio_enc #(.WIDTH(NUM_IRQ)) u_elig_enc (
        .req_i   (elig),
        .idx_o   (sel_idx),
        .valid_o (sel_any)
    );

    assign cand   = irr_q & ~imr_q;
    assign access = io_cs & ~cs_q;
    assign wr     = access & io_we;

    // Only channels strictly above the highest in-service level may nest.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            elig[i] = cand[i] & (~isr_any | (irq_idx_t'(i) < isr_idx));
        end
    end

    always_comb begin
        imr_d     = imr_q;
        vb_d      = vb_q;
        io_dout_d = io_dout_q;
        vec_out_d = vec_out_q;
        eoi_clr   = '0;
        ack_set   = '0;

        if (wr) begin
            case (io_addr)
                IRQ_REG_IRR_CMD: begin
                    if (io_din[IRQ_CMD_SEOI]) begin
                        for (int i = 0; i < NUM_IRQ; i++) begin
                            if (io_din[2:0] == irq_idx_t'(i)) eoi_clr[i] = 1'b1;
                        end
                    end else if (io_din[IRQ_CMD_NSEOI]) begin
                        for (int i = 0; i < NUM_IRQ; i++) begin
                            if (isr_any && isr_idx == irq_idx_t'(i)) eoi_clr[i] = 1'b1;
                        end
                    end
                end
                IRQ_REG_IMR: imr_d = io_din[NUM_IRQ-1:0];
                IRQ_REG_VB:  vb_d  = io_din;
                default:     ;
            endcase
        end

        if (inta) begin
            if (sel_any) begin
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (sel_idx == irq_idx_t'(i)) ack_set[i] = 1'b1;
                end
                vec_out_d = vb_q + 8'(sel_idx);
            end else begin
                vec_out_d = vb_q + 8'(NUM_IRQ - 1);
            end
        end

        if (access) begin
            case (io_addr)
                IRQ_REG_IRR_CMD: io_dout_d = 8'(irr_q);
                IRQ_REG_IMR:     io_dout_d = 8'(imr_q);
                IRQ_REG_VB:      io_dout_d = vb_q;
                default:         io_dout_d = 8'(isr_q);
            endcase
        end

        // A fresh edge outranks the acknowledge clear on the same channel.
        irr_d = (irr_q & ~ack_set) | (irq_in & ~prev_q);
        isr_d = (isr_q & ~eoi_clr) | (AUTO_EOI ? '0 : ack_set);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q      <= '1;
            irr_q       <= '0;
            isr_q       <= '0;
            imr_q       <= '1;
            vb_q        <= VECTOR_BASE;
            cs_q        <= 1'b0;
            io_ack_q    <= 1'b0;
            io_dout_q   <= '0;
            intr_q      <= 1'b0;
            vec_out_q   <= '0;
            vec_valid_q <= 1'b0;
        end else begin
            prev_q      <= irq_in;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            imr_q       <= imr_d;
            vb_q        <= vb_d;
            cs_q        <= io_cs;
            io_ack_q    <= access;
            io_dout_q   <= io_dout_d;
            intr_q      <= |elig;
            vec_out_q   <= vec_out_d;
            vec_valid_q <= inta;
        end
    end

    assign io_dout   = io_dout_q;
    assign io_ack    = io_ack_q;
    assign intr      = intr_q;
    assign vec_out   = vec_out_q;
    assign vec_valid = vec_valid_q;

endmodule

// File: doc/m72_irq_ctrl.md
# m72_irq_ctrl

Parametrised interrupt controller for the M72 main CPU. It replaces the ad-hoc vblank/hint trigger flops with an N-channel, uPD71059-style controller featuring:
- rising-edge request latching, maskable channels, fixed priority with in-service nesting;
- a programmable vector base;
- a one-pulse interrupt-acknowledge handshake that returns an 8-bit vector.

It sits on the CPU I/O bus next to the address-decode PAL and drives the CPU `intr` input.

## Interface
Parameters:
- `NUM_IRQ`, 8, number of request channels, legal 1..8.
- `VECTOR_BASE`, 8'h20, reset value of the vector base register.
- `AUTO_EOI`, 0, 1 = ISR bit is never set on acknowledge.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `irq_in`  in  NUM_IRQ  request lines, synchronous to `clock`; bit 0 is highest priority.
- `io_cs`  in  1  register access strobe; decoded I/O select & stb & cyc.
- `io_we`  in  1  1 = write.
- `io_addr`  in  2  register select.
- `io_din`  in  8  write data.
- `io_dout`  out  8  registered read data.
- `io_ack`  out  1  one-cycle access acknowledge.
- `intr`  out  1  interrupt request to CPU.
- `inta`  in  1  one-cycle acknowledge pulse from CPU.
- `vec_out`  out  8  vector for the last acknowledge.
- `vec_valid`  out  1  one-cycle pulse; `vec_out` is valid.

## Operation
- Edge detect:
  - `prev` register holds last `irq_in`; resets to all ones so lines already high at reset release do not fire.
  - `irq_in & ~prev` sets the corresponding IRR bit.
- Eligibility: `cand = IRR & ~IMR`. A channel is eligible if it is in `cand` and its index is lower than the highest-priority (lowest-index) set ISR bit. With ISR empty, every `cand` bit is eligible.
- `intr` is registered and equals "any eligible channel"; it updates one cycle after any IRR/IMR/ISR change.
- On an `inta` pulse, the controller selects the lowest eligible index k. The next cycle:
  - IRR[k] is cleared.
  - ISR[k] is set (skipped if AUTO_EOI=1).
  - `vec_out` = VB + k (mod 256).
  - `vec_valid` is 1.
- Spurious acknowledge (no eligible channel at `inta`): `vec_out` = VB + NUM_IRQ-1. No IRR or ISR change. `vec_valid` still pulses.
- Registers, all reads zero-extended to 8 bits:
  - addr 0: read IRR. Write = command:
    - bit5 = non-specific EOI: clear highest-priority ISR bit.
    - bit6 = specific EOI: clear ISR[io_din[2:0]], ignored if index ≥ NUM_IRQ.
    - Both bits set: specific EOI wins.
  - addr 1: IMR, read/write; 1 = masked.
  - addr 2: VB, read/write.
  - addr 3: read ISR; writes ignored.
- Masked requests stay latched in IRR and become eligible when unmasked.
- Simultaneous events:
  - New edge on channel k in the same cycle as the acknowledge clears IRR[k]: the set wins, so IRR[k] ends at 1.
  - IMR write in the same cycle as `inta`: selection uses the old IMR.
  - EOI in the same cycle as `inta`: selection uses the old ISR; the EOI clear and the acknowledge set are both applied.

## Timing
- Reset values: IRR=0, ISR=0, IMR=all ones, VB=VECTOR_BASE, `prev`=all ones, `intr`=0, `io_ack`=0, `io_dout`=0, `vec_out`=0, `vec_valid`=0.
- Request latency: `irq_in` rising at edge n sets IRR at n+1 and raises `intr` at n+2.
- Register access:
  - `io_cs` high at edge n gives `io_ack`=1 and valid `io_dout` at n+1.
  - `io_ack` is high for one cycle only, even if `io_cs` is held.
  - A new access requires `io_cs` to drop for one cycle.
  - Writes take effect at n+1.
- Acknowledge: `inta` at edge n gives `vec_valid`/`vec_out` and IRR/ISR updates at n+1, and an updated `intr` at n+2. `inta` pulses closer than 2 cycles apart are a protocol violation.
- Reset asserted mid-handshake clears everything immediately; no vector pulse is produced.

## Structure
- Shared package `m72_pkg`: register address constants (IRQ_REG_IRR_CMD, IRQ_REG_IMR, IRQ_REG_VB, IRQ_REG_ISR) and command bit positions (IRQ_CMD_NSEOI=5, IRQ_CMD_SEOI=6).
- Sub-module `m72_prio_enc` (parameter WIDTH): lowest-set-bit index plus valid flag. Instantiated twice, for the eligible set and for ISR.
- Expected size: ~200 lines of RTL.

## Test plan
- Reset, write IMR=8'h00. Pulse `irq_in[0]` → `intr`=1 two cycles later. Pulse `inta` → `vec_out`=8'h20 with `vec_valid`, ISR=8'h01, IRR=0, `intr`=0.
- Requests on ch3 and ch1 in the same cycle. Acknowledge → vector 8'h21, `intr` stays 0 while ISR[1] is set. Non-specific EOI (write 8'h20 to addr 0) → `intr`=1. Acknowledge → 8'h23.
- IMR=8'hFE with a request on ch2 → `intr`=0, IRR=8'h04. Write IMR=8'h00 → `intr`=1 two cycles later.
- Write VB=8'h40, pulse `inta` with no pending request → `vec_out`=8'h47 (NUM_IRQ=8), ISR unchanged.
- AUTO_EOI=1 build: after acknowledging ch0, ISR=0 and a later ch5 request raises `intr` immediately.
- `irq_in` held high through reset release → no IRR bit set. Reset asserted while IRR=8'h03 → all registers at reset values.
